// File: rtl/dac_multi_serializer.sv
// -----------------------------------------------------------------------------
// dac_multi_serializer
// Takes one multi-channel sample set over a valid/ready handshake. For each
// enabled channel, in ascending index order, it shifts one frame onto a
// TLC5620-style DAC bus (dclk/data/load/ldac).
// Each frame is sent MSB first: {channel index, RNG, code}.
//
// Ports:
//   clk, reset        system clock, synchronous active-high reset
//   s_valid/s_ready   sample-set handshake (s_ready high only when idle)
//   s_data            NCH codes, channel i at [i*DATA_W +: DATA_W]
//   ch_en             channel enable mask, captured together with s_data
//   busy              transfer in progress
//   frame_done        one-cycle pulse once the whole set has been sent
//   dclk, data        serial clock and data (the DAC samples on the dclk fall)
//   load, ldac        active-low input-latch and output-update strobes
//
// Build option: define DAC_PER_CHANNEL_LDAC_EN to issue an ldac pulse after
// every channel's load. Without it, one shared ldac pulse follows the last
// channel, so all DAC outputs update together.
//
// Bus outputs are registered decodes of the current state. They therefore
// appear one clk after the state that produces them, so the first dclk rise
// comes one cycle after accept.
// -----------------------------------------------------------------------------
module dac_multi_serializer #(
  parameter int DATA_W   = 8,
  parameter int NCH      = 4,
  parameter int ADDR_W   = 2,
  parameter int RNG      = 0,
  parameter int HALF_DIV = 20,
  parameter int LOAD_CYC = 40,
  parameter int LDAC_CYC = 40
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    s_valid,
  output logic                    s_ready,
  input  logic [NCH*DATA_W-1:0]   s_data,
  input  logic [NCH-1:0]          ch_en,
  output logic                    busy,
  output logic                    frame_done,
  output logic                    dclk,
  output logic                    data,
  output logic                    load,
  output logic                    ldac
);

  localparam int FW    = ADDR_W + 1 + DATA_W;
  localparam int PER   = 2 * HALF_DIV;
  localparam int MAXC  = (PER > LOAD_CYC) ? ((PER > LDAC_CYC) ? PER : LDAC_CYC)
                                          : ((LOAD_CYC > LDAC_CYC) ? LOAD_CYC : LDAC_CYC);
  localparam int CNT_W = $clog2(MAXC + 1);
  localparam int BIT_W = $clog2(FW);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SHIFT = 3'd1,
    LOAD  = 3'd2,
    LDAC  = 3'd3,
    DONE  = 3'd4
  } state_t;

  state_t                  state_q, state_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [BIT_W-1:0]        bit_q, bit_d;
  logic [ADDR_W-1:0]       ch_q, ch_d;
  logic [NCH-1:0]          rem_q, rem_d;
  logic [NCH*DATA_W-1:0]   sdata_q, sdata_d;
  logic                    dclk_q, dclk_d, data_q, data_d;
  logic                    load_q, load_d, ldac_q, ldac_d;
  logic                    busy_q, busy_d, fd_q, fd_d;
  logic [DATA_W-1:0]       chan_data_s;
  logic [FW-1:0]           word_s;
  logic [NCH-1:0]          rem_left_s;

  // Lowest set bit of the mask, i.e. the next channel to send.
  function automatic logic [ADDR_W-1:0] first_ch(input logic [NCH-1:0] m);
    logic [ADDR_W-1:0] idx;
    idx = {ADDR_W{1'b0}};
    for (int i = NCH - 1; i >= 0; i--) begin
      if (m[i]) idx = ADDR_W'(i);
      else      idx = idx;
    end
    return idx;
  endfunction

  assign s_ready    = (state_q == IDLE) & ~reset;
  assign busy       = busy_q;
  assign frame_done = fd_q;
  assign dclk       = dclk_q;
  assign data       = data_q;
  assign load       = load_q;
  assign ldac       = ldac_q;
  assign word_s     = {ch_q, 1'(RNG), chan_data_s};

  // Select the shadowed code of the channel being sent, and form the mask of channels still pending after it.
  always_comb begin
    chan_data_s = {DATA_W{1'b0}};
    rem_left_s  = rem_q;
    for (int i = 0; i < NCH; i++) begin
      if (ch_q == ADDR_W'(i)) begin
        chan_data_s   = sdata_q[i*DATA_W +: DATA_W];
        rem_left_s[i] = 1'b0;
      end else begin
        rem_left_s[i] = rem_q[i];
      end
    end
  end

  // State register plus registered bus outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= {CNT_W{1'b0}};
      bit_q   <= {BIT_W{1'b0}};
      ch_q    <= {ADDR_W{1'b0}};
      rem_q   <= {NCH{1'b0}};
      sdata_q <= {(NCH*DATA_W){1'b0}};
      dclk_q  <= 1'b0;
      data_q  <= 1'b0;
      load_q  <= 1'b1;
      ldac_q  <= 1'b1;
      busy_q  <= 1'b0;
      fd_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      ch_q    <= ch_d;
      rem_q   <= rem_d;
      sdata_q <= sdata_d;
      dclk_q  <= dclk_d;
      data_q  <= data_d;
      load_q  <= load_d;
      ldac_q  <= ldac_d;
      busy_q  <= busy_d;
      fd_q    <= fd_d;
    end
  end

  // Next-state logic: sequencing of bits, channels and strobe phases.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    ch_d    = ch_q;
    rem_d   = rem_q;
    sdata_d = sdata_q;
    case (state_q)
      IDLE: begin
        if (s_valid) begin
          sdata_d = s_data;
          cnt_d   = {CNT_W{1'b0}};
          bit_d   = BIT_W'(FW - 1);
          ch_d    = first_ch(ch_en);
          rem_d   = ch_en;
          if (|ch_en) state_d = SHIFT;
          else        state_d = DONE;
        end else begin
          state_d = IDLE;
        end
      end
      SHIFT: begin
        if (cnt_q == CNT_W'(PER - 1)) begin
          cnt_d = {CNT_W{1'b0}};
          if (bit_q == {BIT_W{1'b0}}) state_d = LOAD;
          else                        bit_d   = bit_q - BIT_W'(1);
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      LOAD: begin
        if (cnt_q == CNT_W'(LOAD_CYC - 1)) begin
          cnt_d = {CNT_W{1'b0}};
          rem_d = rem_left_s;
`ifdef DAC_PER_CHANNEL_LDAC_EN
          state_d = LDAC;
`else
          // Next enabled channel follows with no dead cycles.
          if (|rem_left_s) begin
            state_d = SHIFT;
            ch_d    = first_ch(rem_left_s);
            bit_d   = BIT_W'(FW - 1);
          end else begin
            state_d = LDAC;
          end
`endif
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      LDAC: begin
        if (cnt_q == CNT_W'(LDAC_CYC - 1)) begin
          cnt_d = {CNT_W{1'b0}};
`ifdef DAC_PER_CHANNEL_LDAC_EN
          if (|rem_q) begin
            state_d = SHIFT;
            ch_d    = first_ch(rem_q);
            bit_d   = BIT_W'(FW - 1);
          end else begin
            state_d = DONE;
          end
`else
          state_d = DONE;
`endif
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output decode of the current state; registered on the next edge.
  always_comb begin
    dclk_d = 1'b0;
    data_d = 1'b0;
    load_d = 1'b1;
    ldac_d = 1'b1;
    fd_d   = 1'b0;
    busy_d = (state_d != IDLE);
    case (state_q)
      IDLE: fd_d = 1'b0;
      SHIFT: begin
        // First half of each bit period is dclk high; the bit holds for both halves.
        dclk_d = (cnt_q < CNT_W'(HALF_DIV));
        data_d = word_s[bit_q];
      end
      LOAD:    load_d = 1'b0;
      LDAC:    ldac_d = 1'b0;
      DONE:    fd_d   = 1'b1;
      default: fd_d   = 1'b0;
    endcase
  end

endmodule
